// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM encoding, bit-timing helpers.
// Latency: n/a (types, constants and functions only).
// Backpressure: n/a.
package uart_pkg;

  // Parity selection values; anything outside ODD/EVEN means no parity bit.
  localparam int UART_CHECK_NONE = 0;
  localparam int UART_CHECK_ODD  = 1;
  localparam int UART_CHECK_EVEN = 2;

  // Frame sequencing states, shared with the receiver.
  typedef enum logic [2:0] {
    UART_IDLE   = 3'd0,
    UART_START  = 3'd1,
    UART_DATA   = 3'd2,
    UART_PARITY = 3'd3,
    UART_STOP   = 3'd4
  } uart_state_e;

  // Clocks per bit: integer floor, so the real baud rate is never below nominal.
  function automatic int calc_bit_cycles(input int sys_clk, input int baud);
    return sys_clk / baud;
  endfunction

  // Width of a counter that must hold 0..bit_cycles-1 (at least one bit).
  function automatic int calc_cnt_width(input int bit_cycles);
    return (bit_cycles > 1) ? $clog2(bit_cycles) : 1;
  endfunction

  // True when the mode inserts a parity bit after the data bits.
  function automatic bit has_parity(input int check);
    return (check == UART_CHECK_ODD) || (check == UART_CHECK_EVEN);
  endfunction

  // Parity bit for up to 8 data bits; unused upper bits must be zero.
  // ODD makes the total count of ones over data+parity odd, EVEN makes it even.
  function automatic logic calc_parity(input logic [7:0] data, input int check);
    if (check == UART_CHECK_ODD) begin
      return ~^data;
    end
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// User-side word handshake plus the serial pin of the UART transmitter.
// Latency: n/a (wires only).
// Backpressure: o_user_tx_ready low means i_user_tx_valid is ignored.
interface uart_tx_if #(
  parameter int P_UART_DATA_WIDTH = 8
) ();

  logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data;
  logic                         i_user_tx_valid;
  logic                         o_user_tx_ready;
  logic                         o_uart_tx;

  // Transmitter side: consumes words, drives ready and the line.
  modport slave (
    input  i_user_tx_data,
    input  i_user_tx_valid,
    output o_user_tx_ready,
    output o_uart_tx
  );

  // User side: offers words, observes ready and the line.
  modport master (
    output i_user_tx_data,
    output i_user_tx_valid,
    input  o_user_tx_ready,
    input  o_uart_tx
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts clocks while enabled, strobes bit_done on the last clock of each bit.
// Latency: bit_done is combinational from the count; it fires P_BIT_CYCLES clocks after enable rises.
// Backpressure: none; dropping i_en clears the count so the next bit starts from zero.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int P_BIT_CYCLES = 5208
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_bit_done
);

  localparam int                CNT_W    = calc_cnt_width(P_BIT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(P_BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign o_bit_done = i_en && (cnt_q == CNT_LAST);

  // Next count: hold at zero while idle, wrap after the last clock of a bit.
  always_comb begin
    cnt_d = cnt_q;
    if (!i_en) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Count register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: latches one word per valid/ready handshake and sends start, LSB-first data, optional parity, stop.
// Latency: start bit appears the clock after accept; ready returns (1+W+Pbit+S)*BIT_CYCLES clocks after accept.
// Backpressure: ready is low for the whole frame; valid is ignored while ready is low.
module uart_tx
  import uart_pkg::*;
#(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BUADRATE   = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0
) (
  input  logic     i_clk,
  input  logic     i_rst,
  uart_tx_if.slave tx_if
);

  localparam int BIT_CYCLES = calc_bit_cycles(P_SYSTEM_CLK, P_UART_BUADRATE);
  localparam bit PARITY_EN  = has_parity(P_UART_CHECK);

  // Data widths are limited to 5..8, so a 3-bit index covers every bit position.
  localparam int              IDX_W     = 3;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(P_UART_DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // Stop width is 1 or 2, so one bit tracks which stop bit is on the line.
  localparam logic STOP_LAST = 1'(P_UART_STOP_WIDTH - 1);

  uart_state_e                  state_q, state_d;
  logic [P_UART_DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]             idx_q,   idx_d;
  logic                         stop_q,  stop_d;
  logic                         par_q,   par_d;
  logic                         tx_q,    tx_d;
  logic                         rdy_q,   rdy_d;

  logic       bit_done;
  logic       cnt_en;
  logic [7:0] data_ext;

  // The bit timer only runs while a frame is on the line, so every frame starts from count zero.
  assign cnt_en = (state_q != UART_IDLE);

  // Zero-extended copy of the incoming word; zero padding leaves parity unchanged.
  assign data_ext = 8'(tx_if.i_user_tx_data);

  uart_baud_cnt #(
    .P_BIT_CYCLES (BIT_CYCLES)
  ) u_baud_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (cnt_en),
    .o_bit_done (bit_done)
  );

  // Next-state and next-output logic; the line value is decided one clock ahead so o_uart_tx is a flop.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    par_d   = par_q;
    tx_d    = tx_q;
    rdy_d   = rdy_q;

    case (state_q)
      UART_IDLE: begin
        tx_d = 1'b1;
        if (tx_if.i_user_tx_valid && rdy_q) begin
          state_d = UART_START;
          shift_d = tx_if.i_user_tx_data;
          par_d   = calc_parity(data_ext, P_UART_CHECK);
          idx_d   = '0;
          stop_d  = 1'b0;
          tx_d    = 1'b0;
          rdy_d   = 1'b0;
        end
      end

      UART_START: begin
        if (bit_done) begin
          state_d = UART_DATA;
          tx_d    = shift_q[0];
        end
      end

      UART_DATA: begin
        if (bit_done) begin
          if (idx_q == IDX_LAST) begin
            if (PARITY_EN) begin
              state_d = UART_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = UART_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            // Shift right so the next data bit is always at position 0.
            idx_d   = idx_q + IDX_ONE;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end

      UART_PARITY: begin
        if (bit_done) begin
          state_d = UART_STOP;
          tx_d    = 1'b1;
        end
      end

      UART_STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          if (stop_q == STOP_LAST) begin
            // Ready rises with the return to IDLE so a held valid is taken on the very next edge.
            state_d = UART_IDLE;
            rdy_d   = 1'b1;
          end else begin
            stop_d = ~stop_q;
          end
        end
      end

      default: begin
        state_d = UART_IDLE;
        tx_d    = 1'b1;
        rdy_d   = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers; reset forces an idle high line at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= UART_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rdy_q   <= rdy_d;
    end
  end

  assign tx_if.o_user_tx_ready = rdy_q;
  assign tx_if.o_uart_tx       = tx_q;

endmodule
